// File: rtl/pheap_arbiter.sv
// pheap_arbiter: round-robin front end sharing one pheap priority queue
// between NUM_REQ requesters. One heap operation is in flight at a time.
// Requests that would overflow or underflow the heap are rejected locally.
// Dequeued priorities are returned to the requester that asked for them.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/deq   : per-requester request strobe and opcode (1 = dequeue)
//   req_prio        : packed priorities, requester k in [32k+31:32k]
//   req_ack/req_err : one-cycle consume / reject-or-timeout pulses
//   resp_valid/prio : one-cycle response pulse to the owner, dequeued value
//   heap_*          : handshake to/from the pheap top
//   count, busy     : tracked occupancy, FSM not idle

package pheapTypes;
  typedef enum logic {ENQ = 1'b0, DEQ = 1'b1} opcode_t;
endpackage

module pheap_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CAPACITY     = 15,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_deq,
  input  logic [NUM_REQ*32-1:0]            req_prio,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [NUM_REQ-1:0]               req_err,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [31:0]                      resp_prio,
  output logic                             heap_valid,
  output pheapTypes::opcode_t              heap_op,
  output logic [31:0]                      heap_prio,
  input  logic                             heap_rdy,
  input  logic                             heap_out_valid,
  input  logic [31:0]                      heap_out_prio,
  output logic [$clog2(CAPACITY+1)-1:0]    count,
  output logic                             busy
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  pheapTypes::opcode_t  op_q, op_d;
  logic [31:0]          hprio_q, hprio_d;
  logic                 hvalid_q, hvalid_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [31:0]          rprio_q, rprio_d;
  logic                 busy_q;

  logic [31:0]          prio_arr [NUM_REQ];
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     grant_next;
  logic [IDX_W-1:0]     cand;
  logic                 grant_deq;
  logic [31:0]          grant_prio;

  // Occupancy never wraps; the local reject checks keep these saturations
  // from ever engaging, the assertion below catches it if they would.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CAPACITY)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      prio_arr[i] = req_prio[i*32 +: 32];
    end
  end

  // Round-robin search: first set request at or above rr_ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    grant_deq  = req_deq[grant_idx];
    grant_prio = prio_arr[grant_idx];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    hprio_d  = hprio_q;
    hvalid_d = hvalid_q;
    count_d  = count_q;
    timer_d  = timer_q;
    ack_d    = '0;
    err_d    = '0;
    rvalid_d = '0;
    rprio_d  = rprio_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // The pointer advances even on a reject so a blocked requester
          // cannot starve the others.
          rr_ptr_d         = grant_next;
          owner_d          = grant_idx;
          ack_d[grant_idx] = 1'b1;
          if (grant_deq ? (count_q == '0) : (count_q == CNT_W'(CAPACITY))) begin
            err_d[grant_idx] = 1'b1;
          end else begin
            op_d     = grant_deq ? pheapTypes::DEQ : pheapTypes::ENQ;
            hprio_d  = grant_prio;
            hvalid_d = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (heap_rdy) begin
          hvalid_d = 1'b0;
          count_d  = (op_q == pheapTypes::ENQ) ? sat_inc(count_q) : sat_dec(count_q);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // One dead cycle so the heap's rdy/valid_out reflect this operation.
        timer_d = '0;
        state_d = (op_q == pheapTypes::DEQ) ? WAIT_RESP : IDLE;
      end
      WAIT_RESP: begin
        if (heap_out_valid) begin
          rprio_d           = heap_out_prio;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
          // Timeout: occupancy is left decremented, the heap did take the DEQ.
          err_d[owner_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= pheapTypes::ENQ;
      hprio_q  <= '0;
      hvalid_q <= 1'b0;
      count_q  <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      rprio_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      hprio_q  <= hprio_d;
      hvalid_q <= hvalid_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rprio_q  <= rprio_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  a_no_wrap: assert property (@(posedge clk) disable iff (rst)
    (state_q == ISSUE && heap_rdy) |->
      !((op_q == pheapTypes::ENQ && count_q == CNT_W'(CAPACITY)) ||
        (op_q == pheapTypes::DEQ && count_q == '0)));

  assign req_ack    = ack_q;
  assign req_err    = err_q;
  assign resp_valid = rvalid_q;
  assign resp_prio  = rprio_q;
  assign heap_valid = hvalid_q;
  assign heap_op    = op_q;
  assign heap_prio  = hprio_q;
  assign count      = count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pheap_arbiter.sv
// Bench for pheap_arbiter: a transaction-level model of the arbiter plus a
// list-based stand-in for the heap, compared against the DUT every cycle,
// and directed scenarios with hand-derived expectations.
module tb_pheap_arbiter;

  localparam int NR  = 4;
  localparam int CAP = 15;
  localparam int TO  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_deq = '0;
  logic [NR*32-1:0]  req_prio;
  logic [NR-1:0]     req_ack, req_err, resp_valid;
  logic [31:0]       resp_prio;
  logic              heap_valid;
  pheapTypes::opcode_t heap_op;
  logic [31:0]       heap_prio;
  logic              heap_rdy = 1'b1;
  logic              heap_out_valid = 1'b0;
  logic [31:0]       heap_out_prio = '0;
  logic [3:0]        count;
  logic              busy;

  logic [31:0]       prio_drv [NR];

  int n_cmp = 0;
  int n_fail = 0;

  pheap_arbiter #(.NUM_REQ(NR), .CAPACITY(CAP), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_deq(req_deq), .req_prio(req_prio),
    .req_ack(req_ack), .req_err(req_err),
    .resp_valid(resp_valid), .resp_prio(resp_prio),
    .heap_valid(heap_valid), .heap_op(heap_op), .heap_prio(heap_prio),
    .heap_rdy(heap_rdy), .heap_out_valid(heap_out_valid), .heap_out_prio(heap_out_prio),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < NR; i++) prio_drv[i] = '0;

  always_comb begin
    for (int i = 0; i < NR; i++) req_prio[i*32 +: 32] = prio_drv[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (evaluated at each rising edge) -----
  int           ph = 0;        // 0 free, 1 op offered, 2 op settling, 3 awaiting result
  int           rrp = 0, mown = 0, mtmr = 0, mcnt = 0;
  bit           mop = 0;
  logic [31:0]  mprio = '0, m_resp = '0;
  logic [31:0]  m_store [$];
  bit           live = 0;
  bit           hold_low = 0;
  logic [NR-1:0] e_ack = '0, e_err = '0, e_rv = '0;
  logic [31:0]  e_rprio = '0, e_hprio = '0;
  logic         e_hv = 0, e_hop = 0, e_busy = 0;
  bit           mock_upd = 0, mock_ov = 0;
  logic [31:0]  mock_op = '0;

  function automatic logic [31:0] pop_max();
    int bi;
    logic [31:0] v;
    if (m_store.size() == 0) return '0;
    bi = 0;
    for (int i = 1; i < m_store.size(); i++) if (m_store[i] > m_store[bi]) bi = i;
    v = m_store[bi];
    m_store.delete(bi);
    return v;
  endfunction

  always @(posedge clk) begin
    logic [NR-1:0] s_rv, s_rd;
    logic [31:0]   s_pr [NR];
    logic          s_hr, s_hov;
    int w, c;
    s_rv = req_valid; s_rd = req_deq; s_hr = heap_rdy; s_hov = heap_out_valid;
    for (int i = 0; i < NR; i++) s_pr[i] = prio_drv[i];
    if (rst) begin
      ph = 0; rrp = 0; mcnt = 0; m_store.delete();
      e_ack = '0; e_err = '0; e_rv = '0; e_rprio = '0; e_hv = 0; e_hop = 0; e_hprio = '0;
      mock_upd = 1; mock_ov = 0; mock_op = '0;
    end else begin
      e_ack = '0; e_err = '0; e_rv = '0;
      if (ph == 0) begin
        if (s_rv != '0) begin
          w = -1;
          for (int i = 0; i < NR; i++) begin
            c = (rrp + i) % NR;
            if (w < 0 && s_rv[c[1:0]]) w = c;
          end
          rrp = (w + 1) % NR;
          mown = w;
          e_ack[w[1:0]] = 1'b1;
          if ((s_rd[w[1:0]] && mcnt == 0) || (!s_rd[w[1:0]] && mcnt == CAP)) begin
            e_err[w[1:0]] = 1'b1;
          end else begin
            mop = s_rd[w[1:0]];
            mprio = s_pr[w];
            e_hv = 1; e_hop = mop;
            if (!mop) e_hprio = mprio;
            ph = 1;
          end
        end
      end else if (ph == 1) begin
        if (s_hr) begin
          e_hv = 0; ph = 2; mock_upd = 1;
          if (!mop) begin
            mcnt++; m_store.push_back(mprio); mock_ov = 0;
          end else begin
            mcnt--; m_resp = pop_max(); mock_ov = !hold_low; mock_op = m_resp;
          end
        end
      end else if (ph == 2) begin
        ph = mop ? 3 : 0; mtmr = 0;
      end else begin
        if (s_hov) begin
          e_rv[mown[1:0]] = 1'b1; e_rprio = m_resp; ph = 0;
        end else if (mtmr == TO - 1) begin
          e_err[mown[1:0]] = 1'b1; ph = 0;
        end else mtmr++;
      end
    end
    e_busy = (ph != 0);
    live = 1;
  end

  // Heap stand-in: presents the model's dequeued value after the handshake.
  always @(negedge clk) begin
    if (mock_upd) begin
      mock_upd = 0;
      heap_out_valid = mock_ov;
      heap_out_prio = mock_op;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (live) begin
      chk("m_req_ack", req_ack, e_ack);
      chk("m_req_err", req_err, e_err);
      chk("m_resp_valid", resp_valid, e_rv);
      chk("m_resp_prio", resp_prio, e_rprio);
      chk("m_heap_valid", heap_valid, e_hv);
      chk("m_heap_op", heap_op, e_hop);
      if (e_hv && !e_hop) chk("m_heap_prio", heap_prio, e_hprio);
      chk("m_count", count, mcnt);
      chk("m_busy", busy, e_busy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; hold_low = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int k, input bit deq, input logic [31:0] p);
    prio_drv[k] = p;
    req_deq[k[1:0]] = deq;
    req_valid[k[1:0]] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ack[k[1:0]]) begin
        req_valid[k[1:0]] = 1'b0;
        return;
      end
    end
    req_valid[k[1:0]] = 1'b0;
    n_cmp++; n_fail++;
    $display("FAIL do_req_ack_timeout: requester %0d got no req_ack, expected one", k);
  endtask

  task automatic wait_idle(output int ncyc, output logic [NR-1:0] rvs, output logic [NR-1:0] errs);
    rvs = '0; errs = '0; ncyc = -1;
    for (int n = 0; n < 300; n++) begin
      if (resp_valid != '0) rvs = resp_valid;
      if (req_err != '0) errs = req_err;
      if (!busy) begin
        ncyc = n;
        return;
      end
      @(negedge clk);
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_idle_timeout: busy still 1, expected 0");
  endtask

  initial begin
    int nc;
    logic [NR-1:0] rvs, errs;
    int order [8];
    int ng;

    @(negedge clk);
    do_reset();
    chk("rst_ack", req_ack, 0);
    chk("rst_heap_valid", heap_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_prio", resp_prio, 0);

    // Requester 2 enqueues 0x10
    do_req(2, 0, 32'h10);
    chk("t1_ack", req_ack, 4'b0100);
    chk("t1_heap_valid", heap_valid, 1);
    chk("t1_heap_op", heap_op, 0);
    chk("t1_heap_prio", heap_prio, 32'h10);
    wait_idle(nc, rvs, errs);
    chk("t1_cycles", nc, 2);
    chk("t1_count", count, 1);

    // Dequeue on empty
    do_reset();
    do_req(0, 1, 0);
    chk("t2_ack", req_ack, 4'b0001);
    chk("t2_err", req_err, 4'b0001);
    chk("t2_heap_valid", heap_valid, 0);
    chk("t2_count", count, 0);

    // Enqueue 5, 9, 3 then requester 1 dequeues the maximum
    do_req(0, 0, 5);  wait_idle(nc, rvs, errs);
    do_req(2, 0, 9);  wait_idle(nc, rvs, errs);
    do_req(3, 0, 3);  wait_idle(nc, rvs, errs);
    chk("t3_count3", count, 3);
    do_req(1, 1, 0);
    wait_idle(nc, rvs, errs);
    chk("t3_resp_owner", rvs, 4'b0010);
    chk("t3_resp_prio", resp_prio, 9);
    chk("t3_err", errs, 0);
    chk("t3_count", count, 2);

    // All four requesters hold enqueue requests
    do_reset();
    for (int i = 0; i < NR; i++) prio_drv[i] = 32'h20 + i;
    req_deq = '0;
    req_valid = 4'hF;
    ng = 0;
    for (int n = 0; n < 200 && ng < 8; n++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        case (req_ack)
          4'b0001: order[ng] = 0;
          4'b0010: order[ng] = 1;
          4'b0100: order[ng] = 2;
          4'b1000: order[ng] = 3;
          default: order[ng] = -1;
        endcase
        ng++;
        if (ng == 8) req_valid = '0;
      end
    end
    req_valid = '0;
    chk("t4_grants", ng, 8);
    for (int i = 0; i < 8; i++) chk("t4_order", order[i], i % 4);
    wait_idle(nc, rvs, errs);
    chk("t4_count", count, 8);

    // Fill to capacity, reject, then dequeue
    for (int i = 0; i < 7; i++) begin
      do_req(0, 0, 32'h40 + i);
      wait_idle(nc, rvs, errs);
    end
    chk("t5_full", count, 15);
    do_req(3, 0, 32'h77);
    chk("t5_rej_ack", req_ack, 4'b1000);
    chk("t5_rej_err", req_err, 4'b1000);
    chk("t5_rej_heap_valid", heap_valid, 0);
    chk("t5_rej_busy", busy, 0);
    do_req(2, 1, 0);
    chk("t5_deq_err", req_err, 0);
    wait_idle(nc, rvs, errs);
    chk("t5_resp_owner", rvs, 4'b0100);
    chk("t5_resp_prio", resp_prio, 32'h46);
    chk("t5_count", count, 14);

    // Result never arrives: timeout after 64 cycles waiting
    hold_low = 1;
    do_req(1, 1, 0);
    wait_idle(nc, rvs, errs);
    chk("t6_cycles", nc, 66);
    chk("t6_err_owner", errs, 4'b0010);
    chk("t6_no_resp", rvs, 0);
    chk("t6_count", count, 13);
    hold_low = 0;

    // Reset while the operation is being offered
    heap_rdy = 1'b0;
    do_req(0, 0, 32'h55);
    repeat (2) @(negedge clk);
    chk("t7_hold_valid", heap_valid, 1);
    chk("t7_hold_prio", heap_prio, 32'h55);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_heap_valid", heap_valid, 0);
    chk("t7_count", count, 0);
    chk("t7_busy", busy, 0);
    chk("t7_ack_err", {req_ack, req_err, resp_valid}, 0);
    chk("t7_prio", {heap_prio, resp_prio}, 0);
    rst = 1'b0;
    heap_rdy = 1'b1;

    // Fresh round-trip after the reset
    do_req(3, 0, 32'hABCD); wait_idle(nc, rvs, errs);
    do_req(3, 1, 0);        wait_idle(nc, rvs, errs);
    chk("t8_resp_owner", rvs, 4'b1000);
    chk("t8_resp_prio", resp_prio, 32'hABCD);
    chk("t8_count", count, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pheap_arbiter.md
# pheap_arbiter

Round-robin front end that shares one `pheap` priority queue between `NUM_REQ` requesters. It arbitrates enqueue/dequeue requests and sequences each one through the heap's `rdy`/`valid` handshake. It tracks heap occupancy so that full-enqueue and empty-dequeue requests are rejected without touching the heap, and it routes each dequeued priority back to the requester that issued the dequeue. It sits between client logic and the `pheap` top and drives that top's `valid`, `priorityIn` and `toperation` inputs.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `CAPACITY`, 15, heap node count (2^LEVELS − 1)
- `RESP_TIMEOUT`, 64, maximum cycles to wait for a dequeue result
- `clk`  in  1  clock; one clock for the whole block
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until `req_ack`
- `req_deq`  in  NUM_REQ  1 = dequeue, 0 = enqueue
- `req_prio`  in  NUM_REQ*32  priority for requester k in bits [32k+31:32k]; ignored for dequeue
- `req_ack`  out  NUM_REQ  one-cycle pulse: request consumed (accepted or rejected)
- `req_err`  out  NUM_REQ  one-cycle pulse with `req_ack`: rejected (full/empty) or dequeue timeout
- `resp_valid`  out  NUM_REQ  one-cycle pulse to the owning requester: `resp_prio` is valid
- `resp_prio`  out  32  dequeued priority
- `heap_valid`  out  1  to `pheap.valid`
- `heap_op`  out  pheapTypes::opcode_t  to `pheap.toperation`; ENQ or DEQ
- `heap_prio`  out  32  to `pheap.priorityIn`
- `heap_rdy`  in  1  from `pheap.rdy`
- `heap_out_valid`  in  1  from `pheap.valid_out`
- `heap_out_prio`  in  32  from `pheap.priorityOut`
- `count`  out  $clog2(CAPACITY+1)  current occupancy
- `busy`  out  1  FSM not in IDLE

## Operation
- All outputs are registered.
- FSM states: IDLE, ISSUE, SETTLE, WAIT_RESP.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit searching upward (with wrap) from `rr_ptr`.
  - Store the winner index in `owner` and set `rr_ptr = winner+1 mod NUM_REQ`.
  - Enqueue with `count == CAPACITY`: pulse `req_ack` and `req_err` for the winner; stay in IDLE.
  - Dequeue with `count == 0`: pulse `req_ack` and `req_err` for the winner; stay in IDLE.
  - Otherwise: load `heap_op`/`heap_prio`, set `heap_valid`, pulse `req_ack` (no `req_err`), and go to ISSUE.
- **ISSUE:**
  - Hold `heap_valid`, `heap_op` and `heap_prio` stable until an edge where `heap_rdy = 1`.
  - At that edge: clear `heap_valid`, update `count` (enqueue +1, dequeue −1), and go to SETTLE.
- **SETTLE:**
  - Lasts exactly one cycle, so the heap's `rdy` and `valid_out` reflect the new operation.
  - Then go to IDLE for an enqueue, or to WAIT_RESP for a dequeue.
- **WAIT_RESP:**
  - The first cycle with `heap_out_valid = 1`: register `resp_prio <= heap_out_prio`, pulse `resp_valid[owner]`, and go to IDLE.
  - If a timeout counter reaches `RESP_TIMEOUT` first: pulse `req_err[owner]` alone (no `req_ack`) and go to IDLE. `count` is not restored.
- Only one heap operation is outstanding at a time. No new grant is made before the return to IDLE.
- `count` saturates: it never wraps past 0 or `CAPACITY`. An internal assertion flags an attempt to wrap.
- `rr_ptr` advances on every grant, including rejected ones. This guarantees fairness: a requester with `req_valid` held is served within NUM_REQ grants.

## Timing
- Reset value of every output is 0: `req_ack`, `req_err`, `resp_valid`, `resp_prio`, `heap_valid`, `heap_op` (ENQ encoding), `heap_prio`, `count`, `busy`.
- Internal state at reset: `rr_ptr = 0`, FSM = IDLE.
- Reset mid-operation abandons the operation with no `resp_valid`. `pheap` shares `rst` and is cleared with the arbiter.
- Reject latency: `req_ack`/`req_err` pulse one cycle after `req_valid` is seen in IDLE.
- Enqueue latency (`heap_rdy` already high):
  - IDLE grant edge: `heap_valid` rises.
  - Next edge: handshake.
  - SETTLE for one cycle, then IDLE.
  - Next grant earliest 3 cycles after the previous one.
- Dequeue latency: the same path plus the WAIT_RESP wait, plus one cycle for the registered `resp_valid`.
- `req_*` inputs are sampled only in IDLE. A change of `req_deq`/`req_prio` while `req_valid` is high and un-acked is a protocol violation.
- `heap_out_valid` is ignored outside WAIT_RESP.

## Test plan
- Reset, then requester 2 enqueues 0x10 → `heap_valid` one cycle later with ENQ/0x10; `req_ack[2]` pulses; `count` = 1 after the handshake.
- Dequeue on empty from requester 0 → `req_ack[0]` and `req_err[0]` pulse together; `heap_valid` stays 0; `count` stays 0.
- Enqueue 5, 9, 3, then requester 1 dequeues → `resp_valid[1]` with `resp_prio` = 9 (max-heap); `count` = 2.
- All four requesters hold enqueue requests continuously → grants occur in order 0,1,2,3,0…; no requester waits more than 4 grants.
- Fill to 15 entries, then enqueue 0x77 → `req_err` pulses, no heap issue; a subsequent dequeue succeeds and `count` = 14.
- Hold `heap_out_valid` low during a dequeue → after 64 cycles in WAIT_RESP, `req_err[owner]` pulses and the FSM returns to IDLE. Assert `rst` during ISSUE in another run → all outputs 0 on the next cycle.
